// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA timing from a divided system clock; sync/blank lag the counters by one pixel tick.
// Optional build macro VGA_FRAME_COUNT_EN adds a 16-bit frame_count output.
`default_nettype none

module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] next_x,
  output logic [31:0] next_y,
  output logic        vga_clk,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic        sync_n,
  output logic        frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  localparam logic [31:0] H_ACT_END   = 32'(H_ACTIVE - 1);
  localparam logic [31:0] H_FRONT_END = 32'(H_ACTIVE + H_FP - 1);
  localparam logic [31:0] H_SYNC_END  = 32'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [31:0] H_LAST      = 32'(H_TOTAL - 1);
  localparam logic [31:0] V_ACT_END   = 32'(V_ACTIVE - 1);
  localparam logic [31:0] V_FRONT_END = 32'(V_ACTIVE + V_FP - 1);
  localparam logic [31:0] V_SYNC_END  = 32'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [31:0] V_LAST      = 32'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    H_ST_ACT   = 2'd0,
    H_ST_FRONT = 2'd1,
    H_ST_SYNC  = 2'd2,
    H_ST_BACK  = 2'd3
  } h_state_t;

  typedef enum logic [1:0] {
    V_ST_ACT   = 2'd0,
    V_ST_FRONT = 2'd1,
    V_ST_SYNC  = 2'd2,
    V_ST_BACK  = 2'd3
  } v_state_t;

  logic [DIV_W-1:0] div;
  logic [31:0]      h_cnt;
  logic [31:0]      v_cnt;
  h_state_t         h_state;
  v_state_t         v_state;

  logic             pix_tick;
  logic             h_wrap;
  logic             v_wrap;
  logic [31:0]      h_cnt_nxt;
  logic [31:0]      v_cnt_nxt;
  h_state_t         h_state_nxt;
  v_state_t         v_state_nxt;

  always_comb begin
    pix_tick    = (div == DIV_LAST);
    h_wrap      = (h_cnt == H_LAST);
    v_wrap      = (v_cnt == V_LAST);
    h_cnt_nxt   = h_wrap ? 32'd0 : h_cnt + 32'd1;
    v_cnt_nxt   = v_cnt;
    h_state_nxt = h_state;
    v_state_nxt = v_state;

    if (h_wrap) begin
      v_cnt_nxt = v_wrap ? 32'd0 : v_cnt + 32'd1;
    end

    // Region changes happen on the tick that leaves the last count of the region.
    case (h_state)
      H_ST_ACT:   if (h_cnt == H_ACT_END)   h_state_nxt = H_ST_FRONT;
      H_ST_FRONT: if (h_cnt == H_FRONT_END) h_state_nxt = H_ST_SYNC;
      H_ST_SYNC:  if (h_cnt == H_SYNC_END)  h_state_nxt = H_ST_BACK;
      H_ST_BACK:  if (h_cnt == H_LAST)      h_state_nxt = H_ST_ACT;
      default:                              h_state_nxt = H_ST_ACT;
    endcase

    if (h_wrap) begin
      case (v_state)
        V_ST_ACT:   if (v_cnt == V_ACT_END)   v_state_nxt = V_ST_FRONT;
        V_ST_FRONT: if (v_cnt == V_FRONT_END) v_state_nxt = V_ST_SYNC;
        V_ST_SYNC:  if (v_cnt == V_SYNC_END)  v_state_nxt = V_ST_BACK;
        V_ST_BACK:  if (v_cnt == V_LAST)      v_state_nxt = V_ST_ACT;
        default:                              v_state_nxt = V_ST_ACT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div         <= '0;
      h_cnt       <= 32'd0;
      v_cnt       <= 32'd0;
      h_state     <= H_ST_ACT;
      v_state     <= V_ST_ACT;
      vga_clk     <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank_n     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= pix_tick ? '0 : div + 1'b1;
      vga_clk     <= (div >= DIV_HALF);
      frame_start <= pix_tick && h_wrap && v_wrap;
      if (pix_tick) begin
        h_cnt   <= h_cnt_nxt;
        v_cnt   <= v_cnt_nxt;
        h_state <= h_state_nxt;
        v_state <= v_state_nxt;
        // Capture the pre-advance states so sync/blank describe the pixel being returned now.
        hsync   <= (h_state != H_ST_SYNC);
        vsync   <= (v_state != V_ST_SYNC);
        blank_n <= (h_state == H_ST_ACT) && (v_state == V_ST_ACT);
      end
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count <= 16'd0;
    end else if (pix_tick && h_wrap && v_wrap) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

  assign next_x = h_cnt;
  assign next_y = v_cnt;
  assign sync_n = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: self-checking bench for vga_timing_gen on a shrunken raster with random resets.
`default_nettype none

module tb_vga_timing_gen;

  localparam int CLK_DIV = 2;
  localparam int HA = 16, HF = 4, HS = 6, HB = 5;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int LINE_CLKS  = HT * CLK_DIV;
  localparam int FRAME_CLKS = LINE_CLKS * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] next_x, next_y;
  logic        vga_clk, hsync, vsync, blank_n, sync_n, frame_start;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count;
`endif

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst), .next_x(next_x), .next_y(next_y), .vga_clk(vga_clk),
    .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .sync_n(sync_n),
    .frame_start(frame_start)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(frame_count)
`endif
  );

  int total = 0, passed = 0, failed = 0;

  // Reference raster: pixel position plus the position of the previously emitted pixel.
  int m_div = 0, m_x = 0, m_y = 0, m_px = 0, m_py = 0;
  bit m_pv = 0, m_fs = 0, m_vclk = 0;
  logic [15:0] m_fc = 16'd0;

  int cyc = 0, max_x = 0, max_y = 0;
  bit meas_en = 0;
  int hs_run = 0, vs_run = 0, bl_run = 0, fs_cnt = 0;
  int last_hs_fall = -1, last_fs = -1;
  logic prev_hs = 1'b1, prev_vs = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  task automatic model_edge();
    if (rst) begin
      m_div = 0; m_x = 0; m_y = 0; m_pv = 0; m_fs = 0; m_vclk = 0; m_fc = 16'd0;
    end else begin
      m_vclk = (m_div >= CLK_DIV / 2);
      m_fs = 0;
      if (m_div == CLK_DIV - 1) begin
        m_div = 0;
        m_pv = 1; m_px = m_x; m_py = m_y;
        m_x++;
        if (m_x == HT) begin
          m_x = 0;
          m_y++;
          if (m_y == VT) begin
            m_y = 0;
            m_fs = 1;
            m_fc++;
          end
        end
      end else begin
        m_div++;
      end
    end
  endtask

  task automatic check_outputs();
    bit exp_hs, exp_vs, exp_bl;
    exp_hs = !(m_pv && m_px >= HA + HF && m_px < HA + HF + HS);
    exp_vs = !(m_pv && m_py >= VA + VF && m_py < VA + VF + VS);
    exp_bl = m_pv && m_px < HA && m_py < VA;
    chk("next_x", next_x, m_x);
    chk("next_y", next_y, m_y);
    chk1("vga_clk", vga_clk, m_vclk);
    chk1("hsync", hsync, exp_hs);
    chk1("vsync", vsync, exp_vs);
    chk1("blank_n", blank_n, exp_bl);
    chk1("sync_n", sync_n, 1'b0);
    chk1("frame_start", frame_start, m_fs);
`ifdef VGA_FRAME_COUNT_EN
    chk("frame_count", {16'd0, frame_count}, {16'd0, m_fc});
`endif
    if (int'(next_x) > max_x) max_x = int'(next_x);
    if (int'(next_y) > max_y) max_y = int'(next_y);
  endtask

  task automatic measure();
    if (hsync === 1'b0 && prev_hs === 1'b1) begin
      chk("hsync_fall_x", next_x, HA + HF + 1);
      if (last_hs_fall >= 0) chk("line_period_clks", cyc - last_hs_fall, LINE_CLKS);
      last_hs_fall = cyc;
    end
    if (hsync === 1'b0) hs_run++;
    else if (hs_run > 0) begin
      chk("hsync_low_clks", hs_run, HS * CLK_DIV);
      hs_run = 0;
    end
    if (vsync === 1'b0 && prev_vs === 1'b1) begin
      chk("vsync_fall_y", next_y, VA + VF);
      chk("vsync_fall_x", next_x, 1);
    end
    if (vsync === 1'b0) vs_run++;
    else if (vs_run > 0) begin
      chk("vsync_low_clks", vs_run, VS * LINE_CLKS);
      vs_run = 0;
    end
    if (blank_n === 1'b1) bl_run++;
    else if (bl_run > 0) begin
      chk("blank_high_clks", bl_run, HA * CLK_DIV);
      bl_run = 0;
    end
    if (frame_start === 1'b1) begin
      fs_cnt++;
      if (last_fs >= 0) chk("frame_period_clks", cyc - last_fs, FRAME_CLKS);
      last_fs = cyc;
    end
    prev_hs = hsync;
    prev_vs = vsync;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check_outputs();
    if (meas_en) measure();
  endtask

  task automatic wait_xy(input int x, input int y, input int limit, input string tag);
    int n = 0;
    while (!(int'(next_x) == x && int'(next_y) == y) && n < limit) begin
      step();
      n++;
    end
    chk1(tag, (int'(next_x) == x && int'(next_y) == y), 1'b1);
  endtask

  initial begin
    int n;

    rst = 1'b1;
    repeat (4) step();
    chk("rst_next_x", next_x, 0);
    chk("rst_next_y", next_y, 0);
    chk1("rst_hsync", hsync, 1'b1);
    chk1("rst_vsync", vsync, 1'b1);
    chk1("rst_blank_n", blank_n, 1'b0);
    chk1("rst_frame_start", frame_start, 1'b0);
    chk1("rst_vga_clk", vga_clk, 1'b0);

    rst = 1'b0;
    meas_en = 1;
    step();
    chk("release_x_1clk", next_x, 0);
    step();
    chk("release_x_2clk", next_x, 1);

    repeat (3 * FRAME_CLKS + 10) step();
    meas_en = 0;
    chk("frame_starts_in_3_frames", fs_cnt, 3);
    chk("max_next_x", max_x, HT - 1);
    chk("max_next_y", max_y, VT - 1);

`ifdef VGA_FRAME_COUNT_EN
    chk("frame_count_after_3", {16'd0, frame_count}, 32'd3);
    force dut.frame_count = 16'hFFFF;
    release dut.frame_count;
    m_fc = 16'hFFFF;
    n = 0;
    while (frame_start !== 1'b1 && n < FRAME_CLKS + 10) begin
      step();
      n++;
    end
    chk1("frame_count_wrap_seen", frame_start, 1'b1);
    chk("frame_count_wrap", {16'd0, frame_count}, 32'd0);
`endif

    wait_xy(HT - 1, VT - 1, FRAME_CLKS + 10, "reach_last_pixel");
    n = 0;
    while (int'(next_x) == HT - 1 && n < 2 * CLK_DIV) begin
      step();
      n++;
    end
    chk("wrap_next_x", next_x, 0);
    chk("wrap_next_y", next_y, 0);
    chk1("wrap_frame_start", frame_start, 1'b1);
    step();
    chk1("frame_start_one_clk", frame_start, 1'b0);

    wait_xy(10, 5, FRAME_CLKS + 10, "reach_mid_line");
    rst = 1'b1;
    step();
    chk("midrst_next_x", next_x, 0);
    chk("midrst_next_y", next_y, 0);
    chk1("midrst_hsync", hsync, 1'b1);
    chk1("midrst_vsync", vsync, 1'b1);
    chk1("midrst_blank_n", blank_n, 1'b0);
    chk1("midrst_frame_start", frame_start, 1'b0);
    rst = 1'b0;
    step();
    step();
    chk("midrst_restart_x", next_x, 1);
    chk("midrst_restart_y", next_y, 0);

    for (int i = 0; i < 25; i++) begin
      n = int'($urandom_range(1, 1200));
      repeat (n) step();
      rst = 1'b1;
      n = int'($urandom_range(1, 3));
      repeat (n) step();
      rst = 1'b0;
    end
    repeat (FRAME_CLKS + 5) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
